lemmings_array: RTL and testbench
=================================

Name: lemmings_array

Overview:
- Array of NUM_LEM independent Lemming controllers, the parametrised successor of the single-lemming walk/fall/dig FSM.
- Adds fall-duration tracking with a parametrised splat threshold: a lemming that falls too long dies permanently.
- Adds a live-population count output.
- Sits between the level/terrain model (bump, ground, dig per lemming) and the display/score logic.

Parameters:
- NUM_LEM, 4, number of independent lemming channels (1..32).
- SPLAT_LIMIT, 20, maximum aaah-high cycles survivable; more than this causes a splat (1..255).
- CNT_W, 8, fall counter width; must satisfy 2^CNT_W > SPLAT_LIMIT+1.
- DIG_MAX, 16, digging cycle limit, used only with DIG_LIMIT_EN.

Ports:
- clk  input  1  clock, rising edge.
- areset  input  1  asynchronous, active-high reset; clock clk.
- bump_left  input  NUM_LEM  per-lemming left-wall bump.
- bump_right  input  NUM_LEM  per-lemming right-wall bump.
- ground  input  NUM_LEM  per-lemming ground-present.
- dig  input  NUM_LEM  per-lemming dig command.
- walk_left  output  NUM_LEM  state is WALK_L.
- walk_right  output  NUM_LEM  state is WALK_R.
- aaah  output  NUM_LEM  state is FALL_L or FALL_R.
- digging  output  NUM_LEM  state is DIG_L or DIG_R.
- splat  output  NUM_LEM  state is SPLAT.
- alive_cnt  output  $clog2(NUM_LEM+1)  number of channels not in SPLAT.

Behaviour:
- Per-channel Moore FSM with states WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT. Outputs are decoded from state only.
- Reset:
  - All channels go to WALK_L with fall_cnt=0; takes effect immediately, including mid-fall or mid-dig.
  - Outputs after reset: walk_left all ones; every other per-lemming output zero; alive_cnt=NUM_LEM.
- Transition priority is ground > dig > bump, the same as the single-lemming block.
- WALK_L:
  - ground=0 -> FALL_L.
  - else dig=1 -> DIG_L.
  - else bump_left=1 -> WALK_R.
  - else stay. bump_right is ignored.
- WALK_R: mirror of WALK_L (FALL_R, DIG_R, bump_right -> WALK_L).
- Simultaneous bump_left and bump_right: the lemming turns.
- DIG_x: ground=0 -> FALL_x; otherwise stay. bump and dig are ignored.
- FALL_x:
  - ground=0 -> stay.
  - ground=1 -> SPLAT if k > SPLAT_LIMIT, else WALK_x. k is the number of cycles aaah has been high, counting the current cycle.
  - bump and dig are ignored. Fall direction is preserved.
- SPLAT: absorbing until areset; all four walk/aaah/digging outputs are 0.
- fall_cnt (CNT_W bits, per channel):
  - Cleared on any transition into FALL_x.
  - Increments each cycle the FSM stays in FALL_x.
  - Saturates at SPLAT_LIMIT+1 and never wraps.
  - Splat test at the landing edge: fall_cnt+1 > SPLAT_LIMIT.
- alive_cnt: combinational popcount of ~splat, valid in the same cycle as the state.
- Channels are fully independent; no cross-channel interaction.

Optional Feature:
- Macro: LEMMINGS_DIG_LIMIT_EN.
- Defined:
  - Per-channel dig_cnt is cleared on entry to DIG_x and increments while in DIG_x.
  - After DIG_MAX cycles of digging with ground=1, the FSM returns to WALK_x. Ground loss still has priority and goes to FALL_x.
- Undefined: digging continues until ground is lost; no dig_cnt register is synthesised.

Decomposition:
- Shared package lemmings_pkg holds:
  - the state enum lem_state_t (3-bit encoding: WALK_L=0, WALK_R=1, FALL_L=2, FALL_R=3, DIG_L=4, DIG_R=5, SPLAT=6);
  - the default constant SPLAT_LIMIT_DEF=20.
- Sub-module lemming_fsm: one channel (FSM, fall_cnt, optional dig_cnt, output decode).
- Top level instantiates lemming_fsm via a generate loop and computes the alive_cnt popcount.

Test Plan:
- Reset and walk: areset pulse, then bump_left[0]=1 for one cycle -> ch0 walk_right=1 next cycle. Other channels stay walk_left=1. alive_cnt=4.
- Safe fall: ground[1]=0 for 20 cycles, then 1 -> aaah[1] high exactly 20 cycles, then walk_left[1]=1.
- Splat: ground[1]=0 for 21 cycles, then 1 -> splat[1]=1, alive_cnt=3. Later bump/dig/ground toggles have no effect until areset.
- Priority: in WALK_R drive ground=0, dig=1, bump_right=1 together -> FALL_R. In WALK_L drive dig=1 and bump_left=1 -> DIG_L. Then ground=0 -> FALL_L.
- Reset mid-fall: areset asserted after 15 fall cycles -> immediate WALK_L, fall_cnt=0. A subsequent 20-cycle fall survives.
- LEMMINGS_DIG_LIMIT_EN build with DIG_MAX=16: dig=1 pulse from WALK_R with ground held 1 -> digging=1 for 16 cycles, then walk_right=1.

Source files
------------

// File: rtl/lemmings_pkg.sv
// Shared types and defaults for the lemming controller array.
package lemmings_pkg;

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } lem_state_t;

  localparam int SPLAT_LIMIT_DEF = 20;

endpackage

// File: rtl/lemming_fsm.sv
// One lemming channel: walk/fall/dig Moore FSM with fall-duration splat check.
// Optional dig time-out is enabled by defining LEMMINGS_DIG_LIMIT_EN.
module lemming_fsm
  import lemmings_pkg::*;
#(
  parameter int SPLAT_LIMIT = SPLAT_LIMIT_DEF,
  parameter int CNT_W       = 8,
  parameter int DIG_MAX     = 16
) (
  input  logic clk,
  input  logic areset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic splat
);

  localparam logic [CNT_W-1:0] FALL_SAT  = CNT_W'(SPLAT_LIMIT + 1);
  localparam logic [CNT_W-1:0] SPLAT_LIM = CNT_W'(SPLAT_LIMIT);

  lem_state_t       r_state;
  lem_state_t       w_next;
  logic [CNT_W-1:0] r_fall_cnt;
  logic [CNT_W-1:0] w_fall_next;
  logic             w_land_splat;
  logic             w_dig_done;
  logic             r_walk_left;
  logic             r_walk_right;
  logic             r_aaah;
  logic             r_digging;
  logic             r_splat;

`ifdef LEMMINGS_DIG_LIMIT_EN
  localparam int               DIG_W    = $clog2(DIG_MAX + 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIG_MAX - 1);

  logic [DIG_W-1:0] r_dig_cnt;
  logic [DIG_W-1:0] w_dig_next;

  assign w_dig_done = (r_dig_cnt == DIG_LAST);
`else
  assign w_dig_done = 1'b0;
`endif

  // Current fall cycle counts too, so fall_cnt+1 > SPLAT_LIMIT becomes >=.
  assign w_land_splat = (r_fall_cnt >= SPLAT_LIM);

  always_comb begin
    w_next = r_state;
    case (r_state)
      WALK_L: begin
        if (!ground)        w_next = FALL_L;
        else if (dig)       w_next = DIG_L;
        else if (bump_left) w_next = WALK_R;
      end
      WALK_R: begin
        if (!ground)         w_next = FALL_R;
        else if (dig)        w_next = DIG_R;
        else if (bump_right) w_next = WALK_L;
      end
      FALL_L:  if (ground) w_next = w_land_splat ? SPLAT : WALK_L;
      FALL_R:  if (ground) w_next = w_land_splat ? SPLAT : WALK_R;
      DIG_L: begin
        if (!ground)         w_next = FALL_L;
        else if (w_dig_done) w_next = WALK_L;
      end
      DIG_R: begin
        if (!ground)         w_next = FALL_R;
        else if (w_dig_done) w_next = WALK_R;
      end
      SPLAT:   w_next = SPLAT;
      default: w_next = WALK_L;
    endcase
  end

  always_comb begin
    w_fall_next = '0;
    if ((r_state == FALL_L || r_state == FALL_R) && (w_next == r_state))
      w_fall_next = (r_fall_cnt == FALL_SAT) ? r_fall_cnt : r_fall_cnt + CNT_W'(1);
  end

`ifdef LEMMINGS_DIG_LIMIT_EN
  always_comb begin
    w_dig_next = '0;
    if ((r_state == DIG_L || r_state == DIG_R) && (w_next == r_state))
      w_dig_next = r_dig_cnt + DIG_W'(1);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_dig_cnt <= '0;
    else        r_dig_cnt <= w_dig_next;
  end
`endif

  // Outputs are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state      <= WALK_L;
      r_fall_cnt   <= '0;
      r_walk_left  <= 1'b1;
      r_walk_right <= 1'b0;
      r_aaah       <= 1'b0;
      r_digging    <= 1'b0;
      r_splat      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_fall_cnt   <= w_fall_next;
      r_walk_left  <= (w_next == WALK_L);
      r_walk_right <= (w_next == WALK_R);
      r_aaah       <= (w_next == FALL_L) || (w_next == FALL_R);
      r_digging    <= (w_next == DIG_L) || (w_next == DIG_R);
      r_splat      <= (w_next == SPLAT);
    end
  end

  assign walk_left  = r_walk_left;
  assign walk_right = r_walk_right;
  assign aaah       = r_aaah;
  assign digging    = r_digging;
  assign splat      = r_splat;

endmodule

// File: rtl/lemmings_array.sv
// Array of independent lemming controllers plus a live-population count.
// Optional dig time-out in each channel is enabled by LEMMINGS_DIG_LIMIT_EN.
module lemmings_array
  import lemmings_pkg::*;
#(
  parameter int NUM_LEM     = 4,
  parameter int SPLAT_LIMIT = SPLAT_LIMIT_DEF,
  parameter int CNT_W       = 8,
  parameter int DIG_MAX     = 16
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [NUM_LEM-1:0]           bump_left,
  input  logic [NUM_LEM-1:0]           bump_right,
  input  logic [NUM_LEM-1:0]           ground,
  input  logic [NUM_LEM-1:0]           dig,
  output logic [NUM_LEM-1:0]           walk_left,
  output logic [NUM_LEM-1:0]           walk_right,
  output logic [NUM_LEM-1:0]           aaah,
  output logic [NUM_LEM-1:0]           digging,
  output logic [NUM_LEM-1:0]           splat,
  output logic [$clog2(NUM_LEM+1)-1:0] alive_cnt
);

  localparam int ALIVE_W = $clog2(NUM_LEM + 1);

  logic [ALIVE_W-1:0] w_alive;

  for (genvar i = 0; i < NUM_LEM; i++) begin : g_lem
    lemming_fsm #(
      .SPLAT_LIMIT(SPLAT_LIMIT),
      .CNT_W      (CNT_W),
      .DIG_MAX    (DIG_MAX)
    ) u_fsm (
      .clk       (clk),
      .areset    (areset),
      .bump_left (bump_left[i]),
      .bump_right(bump_right[i]),
      .ground    (ground[i]),
      .dig       (dig[i]),
      .walk_left (walk_left[i]),
      .walk_right(walk_right[i]),
      .aaah      (aaah[i]),
      .digging   (digging[i]),
      .splat     (splat[i])
    );
  end

  always_comb begin
    w_alive = '0;
    for (int i = 0; i < NUM_LEM; i++)
      w_alive = w_alive + ALIVE_W'(!splat[i]);
  end

  assign alive_cnt = w_alive;

endmodule

// File: tb/tb_lemmings_array.sv
// Self-checking bench for lemmings_array: directed scenarios then randomized
// terrain, every cycle compared against a behavioural lemming model.
module tb_lemmings_array;

  localparam int NL   = 4;
  localparam int SL   = 20;
  localparam int DMAX = 16;
  localparam int AW   = $clog2(NL + 1);

  localparam int M_WALK = 0;
  localparam int M_FALL = 1;
  localparam int M_DIG  = 2;
  localparam int M_DEAD = 3;

  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic [NL-1:0] bump_left, bump_right, ground, dig;
  logic [NL-1:0] walk_left, walk_right, aaah, digging, splat;
  logic [AW-1:0] alive_cnt;

  int checks = 0;
  int errors = 0;

  int mMode[NL];
  int mDir[NL];
  int mFallLen[NL];
  int mDigLen[NL];
  int holeLeft[NL];

  lemmings_array #(
    .NUM_LEM(NL), .SPLAT_LIMIT(SL), .CNT_W(8), .DIG_MAX(DMAX)
  ) dut (
    .clk(clk), .areset(areset),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .dig(dig),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .digging(digging), .splat(splat), .alive_cnt(alive_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NL; i++) begin
      mMode[i] = M_WALK; mDir[i] = 0; mFallLen[i] = 0; mDigLen[i] = 0;
    end
  endtask

  // mFallLen / mDigLen count cycles spent in the mode, including the current one.
  task automatic modelStep();
    for (int i = 0; i < NL; i++) begin
      case (mMode[i])
        M_WALK: begin
          if (!ground[i]) begin mMode[i] = M_FALL; mFallLen[i] = 1; end
          else if (dig[i]) begin mMode[i] = M_DIG; mDigLen[i] = 1; end
          else if ((mDir[i] == 0) ? bump_left[i] : bump_right[i]) mDir[i] = 1 - mDir[i];
        end
        M_DIG: begin
          if (!ground[i]) begin mMode[i] = M_FALL; mFallLen[i] = 1; end
`ifdef LEMMINGS_DIG_LIMIT_EN
          else if (mDigLen[i] == DMAX) mMode[i] = M_WALK;
          else mDigLen[i]++;
`endif
        end
        M_FALL: begin
          if (!ground[i]) mFallLen[i]++;
          else if (mFallLen[i] > SL) mMode[i] = M_DEAD;
          else mMode[i] = M_WALK;
        end
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [NL-1:0] eWL, eWR, eA, eD, eS;
    int eAlive;
    eWL = '0; eWR = '0; eA = '0; eD = '0; eS = '0; eAlive = 0;
    for (int i = 0; i < NL; i++) begin
      eWL[i] = (mMode[i] == M_WALK) && (mDir[i] == 0);
      eWR[i] = (mMode[i] == M_WALK) && (mDir[i] == 1);
      eA[i]  = (mMode[i] == M_FALL);
      eD[i]  = (mMode[i] == M_DIG);
      eS[i]  = (mMode[i] == M_DEAD);
      if (mMode[i] != M_DEAD) eAlive++;
    end
    checkEq({tag, " walk_left"}, 32'(walk_left), 32'(eWL));
    checkEq({tag, " walk_right"}, 32'(walk_right), 32'(eWR));
    checkEq({tag, " aaah"}, 32'(aaah), 32'(eA));
    checkEq({tag, " digging"}, 32'(digging), 32'(eD));
    checkEq({tag, " splat"}, 32'(splat), 32'(eS));
    checkEq({tag, " alive_cnt"}, 32'(alive_cnt), 32'(eAlive));
  endtask

  task automatic applyStimulus(input logic [NL-1:0] bl, input logic [NL-1:0] br,
                               input logic [NL-1:0] g, input logic [NL-1:0] d,
                               input string tag);
    bump_left = bl; bump_right = br; ground = g; dig = d;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic applyReset();
    areset = 1'b1;
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hi;
    logic [NL-1:0] g, bl, br, d;
    bump_left = '0; bump_right = '0; ground = '1; dig = '0;
    modelReset();
    applyReset();

    // Reset and walk
    applyStimulus(4'b0001, 4'b0000, 4'b1111, 4'b0000, "turn");
    checkEq("ch0 turned right", 32'(walk_right[0]), 32'd1);
    checkEq("others walk left", 32'(walk_left[3:1]), 32'b111);
    checkEq("alive after turn", 32'(alive_cnt), 32'd4);

    // Safe fall of exactly SL aaah cycles
    hi = 0;
    for (int k = 0; k < SL; k++) begin
      applyStimulus('0, '0, 4'b1101, '0, "safe fall");
      if (aaah[1]) hi++;
    end
    applyStimulus('0, '0, 4'b1111, '0, "safe land");
    checkEq("safe fall aaah cycles", 32'(hi), 32'(SL));
    checkEq("safe fall walks", 32'(walk_left[1]), 32'd1);

    // One cycle too long: splat, then absorbing
    for (int k = 0; k < SL + 1; k++) applyStimulus('0, '0, 4'b1101, '0, "long fall");
    applyStimulus('0, '0, 4'b1111, '0, "splat land");
    checkEq("splat ch1", 32'(splat[1]), 32'd1);
    checkEq("alive after splat", 32'(alive_cnt), 32'd3);
    for (int k = 0; k < 12; k++)
      applyStimulus(NL'($urandom) & 4'b0010, NL'($urandom) & 4'b0010,
                    NL'($urandom) | 4'b1101, NL'($urandom) & 4'b0010, "dead toggles");
    checkEq("splat persists", 32'(splat[1]), 32'd1);
    applyReset();

    // Priority: ground beats dig beats bump
    applyStimulus(4'b0100, '0, 4'b1111, '0, "ch2 to right");
    applyStimulus('0, 4'b0100, 4'b1011, 4'b0100, "ground first");
    checkEq("ch2 falling", 32'(aaah[2]), 32'd1);
    applyStimulus('0, '0, 4'b1111, '0, "ch2 land");
    checkEq("ch2 lands right", 32'(walk_right[2]), 32'd1);
    applyStimulus(4'b1000, '0, 4'b1111, 4'b1000, "dig first");
    checkEq("ch3 digging", 32'(digging[3]), 32'd1);
    applyStimulus('0, '0, 4'b0111, '0, "dig through");
    checkEq("ch3 falls left", 32'(aaah[3]), 32'd1);
    applyStimulus('0, '0, 4'b1111, '0, "ch3 land");
    checkEq("ch3 lands left", 32'(walk_left[3]), 32'd1);

    // Reset mid-fall, then a survivable fall
    for (int k = 0; k < 15; k++) applyStimulus('0, '0, 4'b1110, '0, "pre-reset fall");
    applyReset();
    checkEq("reset mid-fall", 32'(walk_left), 32'hF);
    for (int k = 0; k < SL; k++) applyStimulus('0, '0, 4'b1110, '0, "post-reset fall");
    applyStimulus('0, '0, 4'b1111, '0, "post-reset land");
    checkEq("post-reset survives", 32'(walk_left[0]), 32'd1);

    // Very long fall must not wrap the counter
    for (int k = 0; k < 300; k++) applyStimulus('0, '0, 4'b1011, '0, "marathon fall");
    applyStimulus('0, '0, 4'b1111, '0, "marathon land");
    checkEq("marathon splat", 32'(splat[2]), 32'd1);
    applyReset();

    // Dig duration
    applyStimulus(4'b0001, '0, 4'b1111, '0, "ch0 to right");
    hi = 0;
    applyStimulus('0, '0, 4'b1111, 4'b0001, "dig pulse");
    if (digging[0]) hi++;
    for (int k = 0; k < 20; k++) begin
      applyStimulus('0, '0, 4'b1111, '0, "dig hold");
      if (digging[0]) hi++;
    end
`ifdef LEMMINGS_DIG_LIMIT_EN
    checkEq("dig cycles", 32'(hi), 32'(DMAX));
    checkEq("dig ends walking right", 32'(walk_right[0]), 32'd1);
`else
    checkEq("dig cycles", 32'(hi), 32'd21);
    checkEq("still digging", 32'(digging[0]), 32'd1);
`endif
    applyReset();

    // Randomized terrain with holes of varied depth
    for (int i = 0; i < NL; i++) holeLeft[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 499) begin
        applyReset();
        for (int i = 0; i < NL; i++) holeLeft[i] = 0;
      end
      for (int i = 0; i < NL; i++) begin
        if (holeLeft[i] > 0) begin
          g[i] = 1'b0; holeLeft[i]--;
        end else begin
          g[i] = 1'b1;
          if ($urandom_range(0, 19) == 0) holeLeft[i] = $urandom_range(1, 26);
        end
        d[i] = ($urandom_range(0, 9) == 0);
      end
      bl = NL'($urandom);
      br = NL'($urandom);
      applyStimulus(bl, br, g, d, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
